// File: rtl/instr_fetch_responder_if.sv
// Instruction-fetch bus: PC-side request, decode-side response, and the program-load port.
interface instr_fetch_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// Fixed-latency instruction store responder: one fetch in flight, word read at accept,
// result held in a response register until the consumer takes it.
module instr_fetch_responder #(
  parameter int          MEM_DEPTH = 256,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_fetch_responder_if.slave   bus
);
  localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] BUSY_LAST = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  rsp_t          rsp_q, rsp_d;
  logic          accept;
  logic          rd_fault, wr_hit;
  logic [AW-1:0] rd_idx, wr_idx;
  logic          unused_wr_lsb;

  logic [31:0]   mem [MEM_DEPTH];

  // Full 32-bit index compare: high address bits never alias onto low words.
  assign rd_idx   = bus.req_addr[AW+1:2];
  assign wr_idx   = bus.wr_addr[AW+1:2];
  assign rd_fault = (bus.req_addr[1:0] != 2'b00) |
                    ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_DEPTH));
  assign wr_hit   = bus.wr_en & ({2'b00, bus.wr_addr[31:2]} < 32'(MEM_DEPTH));
  assign unused_wr_lsb = ^bus.wr_addr[1:0];

  assign bus.req_ready = (state == IDLE) | ((state == RESP) & bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  // Combinational read sampled at the accept edge, so a same-edge write is not seen.
  assign rsp_d.instr = rd_fault ? NOP_INSTR : mem[rd_idx];
  assign rsp_d.addr  = bus.req_addr;
  assign rsp_d.err   = rd_fault;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (LATENCY == 1) ? RESP : BUSY;
          cnt_nx   = 4'd0;
        end
      end
      BUSY: begin
        if (cnt == BUSY_LAST) state_nx = RESP;
        else                  cnt_nx   = cnt + 4'd1;
      end
      RESP: begin
        if (accept) begin
          state_nx = (LATENCY == 1) ? RESP : BUSY;
          cnt_nx   = 4'd0;
        end else if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rsp_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) rsp_q <= rsp_d;
    end
  end

  // Program store is never cleared; loads are accepted in any state, including reset.
  always_ff @(posedge clk) begin
    if (wr_hit) mem[wr_idx] <= bus.wr_data;
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_instr = rsp_q.instr;
  assign bus.rsp_addr  = rsp_q.addr;
  assign bus.rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: directed fetch table, hand-built corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_instr_fetch_responder;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_responder_if bus();

  instr_fetch_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_mem [DEPTH];

  function automatic logic [31:0] pat(input int i);
    return {8'h5A, 8'(i), 16'hBEEF ^ 16'(i)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 32'h0;
    bus.wr_data   = 32'h0;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick;
    bus.wr_en   = 1'b0;
    if ((a >> 2) < DEPTH) model_mem[a >> 2] = d;
  endtask

  // Single isolated fetch with rsp_ready high; checks latency and payload.
  task automatic fetch(input string name, input logic [31:0] a,
                       input logic [31:0] ei, input logic ee);
    int wait_c;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.rsp_ready = 1'b1;
    #1;
    chk({name, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    tick;
    bus.req_valid = 1'b0;
    wait_c = 1;
    #1;
    while (!bus.rsp_valid && wait_c < 20) begin
      tick;
      #1;
      wait_c++;
    end
    chk({name, ".latency"}, 32'(wait_c), 32'(LAT));
    chk({name, ".instr"}, bus.rsp_instr, ei);
    chk({name, ".addr"}, bus.rsp_addr, a);
    chk({name, ".err"}, 32'(bus.rsp_err), 32'(ee));
    tick;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl [9];

    idle_inputs();
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset.rsp_instr", bus.rsp_instr, 32'd0);
    chk("reset.rsp_addr",  bus.rsp_addr,  32'd0);
    chk("reset.rsp_err",   32'(bus.rsp_err), 32'd0);
    chk("reset.req_ready", 32'(bus.req_ready), 32'd1);

    // Preload every word so random reads have a known value.
    for (int i = 0; i < DEPTH; i++) wr_word(32'(i) << 2, pat(i));
    wr_word(32'h0, 32'h0050_0093);
    wr_word(32'h4, 32'h00A0_0113);

    tbl[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
    tbl[2] = '{32'h0000_0002, NOP,           1'b1};
    tbl[3] = '{32'h0000_0400, NOP,           1'b1};
    tbl[4] = '{32'h0000_03FC, pat(255),      1'b0};
    tbl[5] = '{32'h0000_0001, NOP,           1'b1};
    tbl[6] = '{32'hFFFF_FFFC, NOP,           1'b1};
    tbl[7] = '{32'h4000_0000, NOP,           1'b1};
    tbl[8] = '{32'h0000_0080, pat(32),       1'b0};
    for (int i = 0; i < 9; i++) fetch($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].instr, tbl[i].err);

    // Back-to-back issue: second request held while busy, accepted in the response cycle.
    bus.req_valid = 1'b1; bus.req_addr = 32'h0; bus.rsp_ready = 1'b1;
    tick;
    bus.req_addr = 32'h4;
    #1;
    chk("b2b.busy_ready", 32'(bus.req_ready), 32'd0);
    chk("b2b.busy_valid", 32'(bus.rsp_valid), 32'd0);
    tick;
    #1;
    chk("b2b.r0_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b.r0_instr", bus.rsp_instr, 32'h0050_0093);
    chk("b2b.r0_addr",  bus.rsp_addr,  32'h0);
    chk("b2b.r0_ready", 32'(bus.req_ready), 32'd1);
    tick;
    bus.req_valid = 1'b0;
    #1;
    chk("b2b.gap_valid", 32'(bus.rsp_valid), 32'd0);
    tick;
    #1;
    chk("b2b.r1_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b.r1_instr", bus.rsp_instr, 32'h00A0_0113);
    chk("b2b.r1_addr",  bus.rsp_addr,  32'h4);
    tick;
    idle_inputs();

    // Backpressure: response frozen, next request held until release.
    bus.req_valid = 1'b1; bus.req_addr = 32'h0;
    tick;
    bus.req_addr = 32'h4;
    tick;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d.valid", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d.instr", i), bus.rsp_instr, 32'h0050_0093);
      chk($sformatf("bp%0d.addr", i),  bus.rsp_addr,  32'h0);
      chk($sformatf("bp%0d.ready", i), 32'(bus.req_ready), 32'd0);
      tick;
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(bus.req_ready), 32'd1);
    tick;
    bus.req_valid = 1'b0;
    #1;
    chk("bp.gap_valid", 32'(bus.rsp_valid), 32'd0);
    tick;
    #1;
    chk("bp.r1_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp.r1_instr", bus.rsp_instr, 32'h00A0_0113);
    chk("bp.r1_addr",  bus.rsp_addr,  32'h4);
    tick;
    idle_inputs();

    // Out-of-range write must not alias onto word 0.
    wr_word(32'h0000_0400, 32'h1111_1111);
    fetch("oor_wr", 32'h0, 32'h0050_0093, 1'b0);

    // Same-edge write and accept: old word returned.
    bus.req_valid = 1'b1; bus.req_addr = 32'h0; bus.rsp_ready = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 32'h0; bus.wr_data = 32'hDEAD_BEEF;
    tick;
    bus.req_valid = 1'b0; bus.wr_en = 1'b0;
    model_mem[0] = 32'hDEAD_BEEF;
    tick;
    #1;
    chk("rbw.valid", 32'(bus.rsp_valid), 32'd1);
    chk("rbw.instr", bus.rsp_instr, 32'h0050_0093);
    tick;
    idle_inputs();
    fetch("rbw_refetch", 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Reset while busy drops the request.
    bus.req_valid = 1'b1; bus.req_addr = 32'h4; bus.rsp_ready = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("rst_busy.valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy.instr", bus.rsp_instr, 32'd0);
    chk("rst_busy.addr",  bus.rsp_addr,  32'd0);
    chk("rst_busy.err",   32'(bus.rsp_err), 32'd0);
    chk("rst_busy.ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      #1;
      chk($sformatf("rst_busy.quiet%0d", i), 32'(bus.rsp_valid), 32'd0);
    end
    tick;
    idle_inputs();

    // Random traffic against a transaction model: one outstanding fetch with a due cycle.
    begin
      bit          pend = 1'b0;
      int          due  = 0;
      logic [31:0] p_addr = 32'h0, p_instr = 32'h0;
      logic        p_err = 1'b0;
      bit          exp_v, exp_r, fault;
      logic [31:0] a;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
          6, 7:             a = 32'($urandom_range(0, DEPTH * 4 + 15));
          default:          a = $urandom;
        endcase
        bus.req_valid = ($urandom_range(0, 2) != 0);
        bus.req_addr  = a;
        bus.rsp_ready = $urandom_range(0, 1) == 1;
        bus.wr_en     = ($urandom_range(0, 3) == 0);
        bus.wr_addr   = ($urandom_range(0, 7) == 0) ? $urandom
                                                    : 32'($urandom_range(0, DEPTH * 4 - 1));
        bus.wr_data   = $urandom;
        #1;
        exp_v = pend && (cyc >= due);
        exp_r = !pend || (exp_v && bus.rsp_ready);
        chk($sformatf("rnd%0d.valid", cyc), 32'(bus.rsp_valid), 32'(exp_v));
        chk($sformatf("rnd%0d.ready", cyc), 32'(bus.req_ready), 32'(exp_r));
        if (exp_v) begin
          chk($sformatf("rnd%0d.instr", cyc), bus.rsp_instr, p_instr);
          chk($sformatf("rnd%0d.addr", cyc),  bus.rsp_addr,  p_addr);
          chk($sformatf("rnd%0d.err", cyc),   32'(bus.rsp_err), 32'(p_err));
        end
        if (bus.req_valid && exp_r) begin
          fault   = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
          pend    = 1'b1;
          due     = cyc + LAT;
          p_addr  = a;
          p_err   = fault;
          p_instr = fault ? NOP : model_mem[a >> 2];
        end else if (exp_v && bus.rsp_ready) begin
          pend = 1'b0;
        end
        if (bus.wr_en && ((bus.wr_addr >> 2) < DEPTH)) model_mem[bus.wr_addr >> 2] = bus.wr_data;
        tick;
      end
    end

    idle_inputs();
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
